// File: rtl/alu_iter_pkg.sv
// Shared types and funct3 encodings for the iterative execute unit.
// FSM states are plain constants so older netlists keep their encoding.
package alu_iter_pkg;

    typedef logic [1:0] alu_state_t;

    localparam alu_state_t IDLE  = 2'd0;
    localparam alu_state_t SHIFT = 2'd1;
    localparam alu_state_t MUL   = 2'd2;

    localparam logic [2:0] FUNC_ADD  = 3'b000;
    localparam logic [2:0] FUNC_SLL  = 3'b001;
    localparam logic [2:0] FUNC_SLT  = 3'b010;
    localparam logic [2:0] FUNC_SLTU = 3'b011;
    localparam logic [2:0] FUNC_XOR  = 3'b100;
    localparam logic [2:0] FUNC_SR   = 3'b101;
    localparam logic [2:0] FUNC_OR   = 3'b110;
    localparam logic [2:0] FUNC_AND  = 3'b111;
    localparam logic [2:0] FUNC_MUL  = 3'b000;

    localparam logic [2:0] FUNC_BEQ  = 3'b000;
    localparam logic [2:0] FUNC_BNE  = 3'b001;
    localparam logic [2:0] FUNC_BLT  = 3'b100;
    localparam logic [2:0] FUNC_BGE  = 3'b101;
    localparam logic [2:0] FUNC_BLTU = 3'b110;
    localparam logic [2:0] FUNC_BGEU = 3'b111;

    localparam logic [2:0] FUNC_SH1ADD = 3'b010;
    localparam logic [2:0] FUNC_SH2ADD = 3'b100;
    localparam logic [2:0] FUNC_SH3ADD = 3'b110;

    function automatic logic isShadd(input logic [2:0] f3);
        return (f3 == FUNC_SH1ADD) || (f3 == FUNC_SH2ADD) || (f3 == FUNC_SH3ADD);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Operand/result bundle between the datapath (master) and the execute unit (slave).
interface alu_iter_if #(
    parameter int XLEN = 32
);
    logic                    start;
    logic [2:0]              f3;
    logic                    arith_bit;
    logic                    branch;
    logic                    shadd;
    logic                    mul;
    logic [XLEN-1:0]         src_a;
    logic [XLEN-1:0]         src_b;
    logic [XLEN-1:0]         out;
    logic [$clog2(XLEN)-1:0] shamt_out;
    logic                    done;
    logic                    busy;

    modport master (
        output start, f3, arith_bit, branch, shadd, mul, src_a, src_b,
        input  out, shamt_out, done, busy
    );

    modport slave (
        input  start, f3, arith_bit, branch, shadd, mul, src_a, src_b,
        output out, shamt_out, done, busy
    );
endinterface

// File: rtl/alu_iter_step.sv
// One iteration of the execute unit: a shifter limited to 0..SHIFT_STEP positions
// and the accumulate of one SHIFT_STEP-bit slice of the multiplier.
module alu_step #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
)(
    input  logic [XLEN-1:0]         acc,
    input  logic [$clog2(XLEN)-1:0] amt,
    input  logic                    left,
    input  logic                    arith,
    input  logic [XLEN-1:0]         mcand,
    input  logic [SHIFT_STEP-1:0]   mbits,
    output logic [XLEN-1:0]         shifted,
    output logic [XLEN-1:0]         sum
);
    localparam int AW = $clog2(XLEN);

    logic [XLEN-1:0] pp;

    // Only constant shift distances up to SHIFT_STEP exist, so this is a small mux, not a barrel shifter.
    always_comb begin
        shifted = acc;
        for (int j = 1; j <= SHIFT_STEP; j++) begin
            if (amt == AW'(j)) begin
                if (left)
                    shifted = acc << j;
                else if (arith)
                    shifted = XLEN'($signed(acc) >>> j);
                else
                    shifted = acc >> j;
            end
        end
    end

    always_comb begin
        pp = '0;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (mbits[i])
                pp = pp + (mcand << i);
        end
        sum = acc + pp;
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative integer execute unit: single-cycle ALU/branch/shadd ops plus
// multi-cycle shifts and an optional shift-add multiplier sharing one accumulator.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter bit SHADD_EN   = 1'b1,
    parameter bit MUL_EN     = 1'b0
)(
    input logic       clk,
    input logic       rst,
    alu_iter_if.slave bus
);
    localparam int AW = $clog2(XLEN);
    typedef logic [AW-1:0] sham_t;
    localparam sham_t STEP_AMT = sham_t'(SHIFT_STEP);

    alu_state_t      state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    sham_t           cnt;
    logic            dir_left;
    logic            arith;

    sham_t           shamt;
    sham_t           k;
    logic            use_branch, use_shadd, use_mul;
    logic            shift_go, mul_go, last_shift, last_mul, cmp;
    logic [XLEN-1:0] alu_res, branch_res, shadd_res, idle_res;
    logic [XLEN-1:0] shifted, sum, mplier_next;

    // Mode priority: branch, then shadd, then mul, then the plain ALU.
    assign shamt      = bus.src_b[AW-1:0];
    assign use_branch = bus.branch;
    assign use_shadd  = !bus.branch && SHADD_EN && bus.shadd;
    assign use_mul    = !bus.branch && !use_shadd && MUL_EN && bus.mul;
    assign shift_go   = bus.start && !use_branch && !use_shadd && !use_mul &&
                        ((bus.f3 == FUNC_SLL) || (bus.f3 == FUNC_SR)) && (shamt != '0);
    assign mul_go     = bus.start && use_mul && (bus.f3 == FUNC_MUL) && (bus.src_b != '0);

    always_comb begin
        cmp = 1'b0;
        case (bus.f3)
            FUNC_BEQ:  cmp = bus.src_a == bus.src_b;
            FUNC_BNE:  cmp = bus.src_a != bus.src_b;
            FUNC_BLT:  cmp = $signed(bus.src_a) < $signed(bus.src_b);
            FUNC_BGE:  cmp = $signed(bus.src_a) >= $signed(bus.src_b);
            FUNC_BLTU: cmp = bus.src_a < bus.src_b;
            FUNC_BGEU: cmp = bus.src_a >= bus.src_b;
            default:   cmp = 1'b0;
        endcase
        branch_res    = '0;
        branch_res[0] = cmp;
    end

    assign shadd_res = isShadd(bus.f3) ? (bus.src_a << bus.f3[2:1]) + bus.src_b : '0;

    // Shifts fall to the default arm: with shamt=0 the result is simply src_a.
    always_comb begin
        case (bus.f3)
            FUNC_ADD:  alu_res = bus.arith_bit ? bus.src_a - bus.src_b : bus.src_a + bus.src_b;
            FUNC_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
            FUNC_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
            FUNC_XOR:  alu_res = bus.src_a ^ bus.src_b;
            FUNC_OR:   alu_res = bus.src_a | bus.src_b;
            FUNC_AND:  alu_res = bus.src_a & bus.src_b;
            default:   alu_res = bus.src_a;
        endcase
    end

    assign idle_res    = use_branch ? branch_res :
                         use_shadd  ? shadd_res  :
                         use_mul    ? '0         : alu_res;

    assign k           = (cnt >= STEP_AMT) ? STEP_AMT : cnt;
    assign last_shift  = cnt <= STEP_AMT;
    assign mplier_next = mplier >> SHIFT_STEP;
    assign last_mul    = mplier_next == '0;

    alu_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_step (
        .acc     (acc),
        .amt     (k),
        .left    (dir_left),
        .arith   (arith),
        .mcand   (mcand),
        .mbits   (mplier[SHIFT_STEP-1:0]),
        .shifted (shifted),
        .sum     (sum)
    );

    // The final iteration's result is combinational so done lines up with the last step.
    always_comb begin
        bus.out       = idle_res;
        bus.done      = !(shift_go || mul_go);
        bus.busy      = 1'b0;
        bus.shamt_out = '0;
        case (state)
            SHIFT: begin
                bus.out       = shifted;
                bus.done      = last_shift;
                bus.busy      = 1'b1;
                bus.shamt_out = cnt;
            end
            MUL: begin
                bus.out  = sum;
                bus.done = last_mul;
                bus.busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            dir_left <= 1'b0;
            arith    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (shift_go) begin
                        acc      <= bus.src_a;
                        cnt      <= shamt;
                        dir_left <= bus.f3 == FUNC_SLL;
                        arith    <= bus.arith_bit && (bus.f3 == FUNC_SR);
                        state    <= SHIFT;
                    end else if (mul_go) begin
                        acc    <= '0;
                        mcand  <= bus.src_a;
                        mplier <= bus.src_b;
                        state  <= MUL;
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt - k;
                    if (last_shift)
                        state <= IDLE;
                end
                MUL: begin
                    acc    <= sum;
                    mcand  <= mcand << SHIFT_STEP;
                    mplier <= mplier_next;
                    if (last_mul)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Drives three alu_iter configurations (STEP 1, STEP 4, STEP 2 with MUL) with the same
// operations and compares every cycle against a plain-arithmetic reference model.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  f3;
    logic        arith_bit, branch, shadd, mul;
    logic [31:0] src_a, src_b;

    int checks = 0;
    int errors = 0;

    int steps [3] = '{1, 4, 2};
    bit mulen [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    alu_iter_if #(.XLEN(32)) if1 ();
    alu_iter_if #(.XLEN(32)) if4 ();
    alu_iter_if #(.XLEN(32)) ifm ();

    assign if1.start = start;  assign if4.start = start;  assign ifm.start = start;
    assign if1.f3 = f3;        assign if4.f3 = f3;        assign ifm.f3 = f3;
    assign if1.arith_bit = arith_bit;  assign if4.arith_bit = arith_bit;  assign ifm.arith_bit = arith_bit;
    assign if1.branch = branch;  assign if4.branch = branch;  assign ifm.branch = branch;
    assign if1.shadd = shadd;    assign if4.shadd = shadd;    assign ifm.shadd = shadd;
    assign if1.mul = mul;        assign if4.mul = mul;        assign ifm.mul = mul;
    assign if1.src_a = src_a;    assign if4.src_a = src_a;    assign ifm.src_a = src_a;
    assign if1.src_b = src_b;    assign if4.src_b = src_b;    assign ifm.src_b = src_b;

    logic [31:0] out_v  [3];
    logic        done_v [3];
    logic        busy_v [3];
    logic [4:0]  sham_v [3];

    assign out_v[0] = if1.out;   assign done_v[0] = if1.done;  assign busy_v[0] = if1.busy;  assign sham_v[0] = if1.shamt_out;
    assign out_v[1] = if4.out;   assign done_v[1] = if4.done;  assign busy_v[1] = if4.busy;  assign sham_v[1] = if4.shamt_out;
    assign out_v[2] = ifm.out;   assign done_v[2] = ifm.done;  assign busy_v[2] = ifm.busy;  assign sham_v[2] = ifm.shamt_out;

    alu_iter #(.XLEN(32), .SHIFT_STEP(1), .SHADD_EN(1'b1), .MUL_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    alu_iter #(.XLEN(32), .SHIFT_STEP(4), .SHADD_EN(1'b1), .MUL_EN(1'b0)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    alu_iter #(.XLEN(32), .SHIFT_STEP(2), .SHADD_EN(1'b1), .MUL_EN(1'b1)) dutm (.clk(clk), .rst(rst), .bus(ifm));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Result and cycle count of one operation, straight from the instruction semantics.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  input logic ab, input logic br, input logic sh, input logic ml,
                                  input int step, input bit mul_en,
                                  output logic [31:0] res, output int lat, output bit is_shift);
        int amt;
        int bits;
        amt      = int'(b[4:0]);
        lat      = 0;
        is_shift = 1'b0;
        res      = 32'h0;
        if (br) begin
            case (f)
                3'b000: res = {31'h0, a == b};
                3'b001: res = {31'h0, a != b};
                3'b100: res = {31'h0, $signed(a) < $signed(b)};
                3'b101: res = {31'h0, $signed(a) >= $signed(b)};
                3'b110: res = {31'h0, a < b};
                3'b111: res = {31'h0, a >= b};
                default: res = 32'h0;
            endcase
        end else if (sh) begin
            if (f == 3'b010 || f == 3'b100 || f == 3'b110)
                res = (a << f[2:1]) + b;
        end else if (ml && mul_en) begin
            if (f == 3'b000) begin
                res  = a * b;
                bits = 0;
                for (int i = 0; i < 32; i++)
                    if (b[i]) bits = i + 1;
                lat = (bits + step - 1) / step;
            end
        end else begin
            case (f)
                3'b000: res = ab ? a - b : a + b;
                3'b001: begin
                    res      = a << amt;
                    lat      = (amt + step - 1) / step;
                    is_shift = amt != 0;
                end
                3'b010: res = {31'h0, $signed(a) < $signed(b)};
                3'b011: res = {31'h0, a < b};
                3'b100: res = a ^ b;
                3'b101: begin
                    res      = ab ? 32'($signed(a) >>> amt) : a >> amt;
                    lat      = (amt + step - 1) / step;
                    is_shift = amt != 0;
                end
                3'b110: res = a | b;
                default: res = a & b;
            endcase
        end
    endfunction

    // Entered and left at a falling edge with every unit idle; restart>0 pulses a stray start in that cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                 input logic ab, input logic br, input logic sh, input logic ml,
                                 input int restart);
        logic [31:0] res [3];
        int          lat [3];
        bit          shf [3];
        int          amt, maxlat, minlat;
        amt    = int'(b[4:0]);
        maxlat = 0;
        minlat = 1000;
        for (int i = 0; i < 3; i++) begin
            model(a, b, f, ab, br, sh, ml, steps[i], mulen[i], res[i], lat[i], shf[i]);
            if (lat[i] > maxlat) maxlat = lat[i];
            if (lat[i] < minlat) minlat = lat[i];
        end
        src_a = a; src_b = b; f3 = f; arith_bit = ab; branch = br; shadd = sh; mul = ml;
        start = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d c0 done", i), 32'(done_v[i]), 32'(lat[i] == 0));
            checkOutput($sformatf("u%0d c0 busy", i), 32'(busy_v[i]), 32'h0);
            if (lat[i] == 0)
                checkOutput($sformatf("u%0d c0 out", i), out_v[i], res[i]);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; f3 = 3'($urandom); arith_bit = 1'($urandom);
        for (int c = 1; c <= maxlat + 1; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (c < lat[i]) begin
                    checkOutput($sformatf("u%0d c%0d done", i, c), 32'(done_v[i]), 32'h0);
                    checkOutput($sformatf("u%0d c%0d busy", i, c), 32'(busy_v[i]), 32'h1);
                end else if (c == lat[i]) begin
                    checkOutput($sformatf("u%0d c%0d done", i, c), 32'(done_v[i]), 32'h1);
                    checkOutput($sformatf("u%0d c%0d busy", i, c), 32'(busy_v[i]), 32'h1);
                    checkOutput($sformatf("u%0d c%0d out", i, c), out_v[i], res[i]);
                end else begin
                    checkOutput($sformatf("u%0d c%0d idle busy", i, c), 32'(busy_v[i]), 32'h0);
                    checkOutput($sformatf("u%0d c%0d idle done", i, c), 32'(done_v[i]), 32'h1);
                    checkOutput($sformatf("u%0d c%0d idle shamt", i, c), 32'(sham_v[i]), 32'h0);
                end
                if (shf[i] && c <= lat[i])
                    checkOutput($sformatf("u%0d c%0d shamt", i, c), 32'(sham_v[i]),
                                32'(amt - (c - 1) * steps[i]));
            end
            if (c == restart && minlat >= restart) begin
                start = 1'b1; branch = 1'b0; shadd = 1'b0; mul = 1'b0;
                f3 = 3'b001; src_a = $urandom; src_b = $urandom;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          mode;
        int          rs;
        logic [31:0] a, b;
        logic [2:0]  f;
        logic        ab, br, sh, ml;

        rst = 1'b1; start = 1'b0; f3 = 3'b000; arith_bit = 1'b0;
        branch = 1'b0; shadd = 1'b0; mul = 1'b0; src_a = 32'h0; src_b = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d reset busy", i), 32'(busy_v[i]), 32'h0);
            checkOutput($sformatf("u%0d reset done", i), 32'(done_v[i]), 32'h1);
            checkOutput($sformatf("u%0d reset shamt", i), 32'(sham_v[i]), 32'h0);
        end
        rst = 1'b0;

        $display("[TB] directed operations");
        applyStimulus(32'h1, 32'd5, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(32'h80000000, 32'd7, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(32'd7, 32'hFFFFFFFD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(32'd5, 32'd7, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(32'hFFFFFFFF, 32'd1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(32'hFFFFFFFF, 32'd1, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(32'd3, 32'd10, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(32'h12345678, 32'h0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(32'h87654321, 32'h20, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(32'hFFFFFFFF, 32'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(32'h1, 32'h80000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(32'hDEADBEEF, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(32'h1, 32'd20, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        $display("[TB] reset during a shift");
        src_a = 32'h1; src_b = 32'd20; f3 = 3'b001; arith_bit = 1'b0;
        branch = 1'b0; shadd = 1'b0; mul = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d abort busy", i), 32'(busy_v[i]), 32'h0);
            checkOutput($sformatf("u%0d abort done", i), 32'(done_v[i]), 32'h1);
            checkOutput($sformatf("u%0d abort shamt", i), 32'(sham_v[i]), 32'h0);
        end
        rst = 1'b0;

        $display("[TB] random operations");
        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 3));
            a = $urandom; b = $urandom; f = 3'($urandom); ab = 1'($urandom);
            br = 1'b0; sh = 1'b0; ml = 1'b0;
            case (mode)
                0: br = 1'b1;
                1: sh = 1'b1;
                2: begin
                    ml = 1'b1;
                    if ($urandom_range(0, 3) != 0) f = 3'b000;
                    if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
                end
                default: ;
            endcase
            rs = ($urandom_range(0, 4) == 0) ? 2 : 0;
            applyStimulus(a, b, f, ab, br, sh, ml, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised iterative integer execute unit for the multi-cycle RV32 core; the successor to the fixed 1-bit/cycle ALU.
- Owns its own shift/multiply iteration state. The datapath no longer recirculates the shift amount through r2.
- Single-cycle ops return in the start cycle. Shifts take SHIFT_STEP bits per cycle. An optional shift-add multiplier (MUL) shares the accumulator.
- The datapath latches `out` on `done`, exactly as it does for ir.

Parameters:
- XLEN, 32: datapath width; power of 2, at least 8.
- SHIFT_STEP, 1: bits shifted or multiplier bits consumed per cycle; power of 2, 1..XLEN/2.
- SHADD_EN, 1: enables Zba sh1add/sh2add/sh3add.
- MUL_EN, 0: enables the iterative MUL (low XLEN bits).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin operation; ignored while busy
- f3  in  3  funct3 (ALU, branch, or shadd select)
- arith_bit  in  1  SUB / SRA select
- branch  in  1  branch-compare mode
- shadd  in  1  shift-add mode (ignored if !SHADD_EN)
- mul  in  1  multiply mode (ignored if !MUL_EN)
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B; shift amount = src_b[$clog2(XLEN)-1:0]
- out  out  XLEN  result; valid only when done=1
- shamt_out  out  $clog2(XLEN)  remaining shift count (debug)
- done  out  1  result valid this cycle
- busy  out  1  multi-cycle op in progress

Behaviour:
- States: IDLE, SHIFT, MUL.
- Reset: state=IDLE, acc=0, cnt=0, mplier=0. Outputs: busy=0, done=1, shamt_out=0.
- Reset mid-operation aborts; the unit is IDLE the next cycle with no stale done.
- IDLE combinational path:
  - out = f(src_a, src_b, f3, ...) with done=1 in the same cycle.
  - This covers ADD/SUB (arith_bit selects SUB), SLT, SLTU, XOR, OR, AND, branch compares, shadd, shift with shamt=0, and mul with src_b=0 (out=0).
- Branch mode:
  - out[0] = compare; f3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - out[XLEN-1:1]=0. f3 010/011 give out=0.
- shadd: out = (src_a << f3[2:1]) + src_b for f3 ∈ {010, 100, 110}; other f3 give out=0.
- Shift start (f3 001 or 101, shamt≠0, start in IDLE):
  - Capture acc<=src_a, cnt<=shamt, dir, and arith (arith_bit && f3=101).
  - done=0 in the start cycle; go to SHIFT.
- SHIFT state:
  - Each cycle k = (cnt ≥ SHIFT_STEP) ? SHIFT_STEP : cnt; acc <= acc shifted by k; cnt <= cnt−k.
  - SRA fills with the captured sign bit.
  - When cnt ≤ SHIFT_STEP: final cycle. done=1, out = acc shifted by cnt (combinational); next state IDLE.
  - Otherwise done=0. busy=1 throughout SHIFT.
  - shamt_out = cnt in SHIFT, 0 in IDLE.
  - Latency: done arrives ceil(shamt/SHIFT_STEP) cycles after the start cycle.
- MUL (MUL_EN, mul=1, f3=000, src_b≠0):
  - Capture acc=0, mcand=src_a, mplier=src_b; go to MUL.
  - Each cycle: acc += mcand × mplier[SHIFT_STEP-1:0] (sum of shifted mcand terms); mcand <<= SHIFT_STEP; mplier >>= SHIFT_STEP.
  - Final cycle is the one whose post-step mplier is 0. done=1 and out = acc + this step's partial product (combinational); then IDLE.
  - Maximum XLEN/SHIFT_STEP cycles after start.
  - mul=1 with f3≠000: single cycle, out=0.
- Operand capture: all operands are captured on start, so inputs need not be held.
- Handshake:
  - done is a one-cycle pulse after multi-cycle ops; out is not held afterwards.
  - start during busy is ignored, with no effect on state.
  - A new start in the cycle after a final done is accepted.
- Width: all arithmetic is modulo 2^XLEN; overflow is discarded.

Decomposition:
- Shared package:
  - alu_state_t (IDLE/SHIFT/MUL).
  - Existing FUNC_* f3 constants; add FUNC_MUL=3'b000.
  - sham_t generalised to logic[$clog2(XLEN)-1:0].
  - isShadd() helper.
- One natural sub-module: alu_step. It is a combinational SHIFT_STEP-bounded shifter plus partial-product adder, shared by the SHIFT final-cycle output path and the state update.

Test Plan:
- XLEN=32, STEP=1, SLL a=0x1, b=5 → done=0 for cycles 0–4, done=1 in cycle 5, out=0x20; shamt_out=5,4,3,2,1 in cycles 1–5.
- STEP=4, SRA a=0x80000000, b=7 (arith_bit=1, f3=101) → cycle1 cnt=7, cycle2 cnt=3 with done=1, out=0xFF000000.
- Single-cycle ops in the start cycle:
  - ADD a=7, b=0xFFFFFFFD → out=4, done=1.
  - SUB a=5, b=7 → out=0xFFFFFFFE.
  - Branch BLT a=0xFFFFFFFF, b=1 → out=1; BLTU with the same operands → out=0.
- SHADD_EN: sh2add (f3=100) a=3, b=10 → out=22, done=1 in the start cycle. Shift with b=0 → out=a, done=1 in the start cycle.
- MUL_EN=1, STEP=2:
  - a=0xFFFFFFFF, b=3 → done in cycle 1, out=0xFFFFFFFD.
  - a=1, b=0x80000000 → done in cycle 16, out=0x80000000.
  - b=0 → out=0 in the start cycle.
- Control robustness:
  - SLL a=1, b=20, STEP=1: assert rst in cycle 3 → cycle 4 busy=0, done=1, shamt_out=0.
  - A second start pulse in cycle 2 of a running shift is ignored; the original result appears on schedule.
